demux12_stream: RTL
===================

Name: demux12_stream

Overview:
- 1-to-2 stream demultiplexer: the counterpart of the 32-bit 2:1 mux in the Proyecto_2 datapath.
- Steers each accepted input word to output channel 0 or 1 according to SEL, which is sampled with the word.
- Each output channel has its own small FIFO, so a stalled consumer on one channel does not corrupt data bound for the other.
- Sits between a single producer (e.g. result bus) and two consumers (e.g. register writeback / memory store path).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEL  in  1  destination of the current input word: 0 → channel 0, 1 → channel 1.
- IN_VALID  in  1  producer has a word on IN_DATA.
- IN_READY  out  1  block can accept a word for the channel selected by SEL.
- IN_DATA  in  WIDTH  input word.
- OUT0_VALID  out  1  channel 0 FIFO not empty.
- OUT0_READY  in  1  channel 0 consumer accepts the head word.
- OUT0_DATA  out  WIDTH  channel 0 head word.
- OUT1_VALID  out  1  channel 1 FIFO not empty.
- OUT1_READY  in  1  channel 1 consumer accepts the head word.
- OUT1_DATA  out  WIDTH  channel 1 head word.
- LEVEL0  out  $clog2(DEPTH)+1  channel 0 occupancy.
- LEVEL1  out  $clog2(DEPTH)+1  channel 1 occupancy.

Behaviour:
- Reset (async assert, release on the next edge):
  - pointers and levels go to 0.
  - OUT0_VALID = OUT1_VALID = 0; LEVEL0 = LEVEL1 = 0.
  - OUTx_DATA = 0; storage is cleared.
  - IN_READY = 1 once reset is deasserted.
- IN_READY is combinational: ~full[SEL]. It depends only on the selected channel's full flag, never on the other channel.
- Push: IN_VALID & IN_READY at a rising edge. IN_DATA is written at the tail of FIFO[SEL], and only that channel's level increments.
- Pop on channel x: OUTx_VALID & OUTx_READY at a rising edge. The head advances and the level decrements.
- Latency: a word pushed at edge N is visible at OUTx_DATA with OUTx_VALID = 1 after edge N. There is no combinational pass-through from IN_DATA to OUTx_DATA.
- OUTx_DATA always shows the head entry. Its value is don't-care while OUTx_VALID = 0, but it must be stable while OUTx_VALID = 1 and OUTx_READY = 0.
- Ordering: FIFO order per channel. No ordering relation is kept between channels.
- Simultaneous push and pop on the same channel:
  - Not full: the level is unchanged, and both operations take effect.
  - Full: IN_READY = 0, so the push is not taken even though a pop occurs that cycle. This avoids a ready→ready combinational path.
- Simultaneous push on one channel and pop on the other: independent. Each level updates separately.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty are derived from the level counter, not from pointer compare.
- Full/empty flags:
  - full[x] = (LEVELx == DEPTH).
  - empty[x] = (LEVELx == 0).
  - OUTx_VALID = ~empty[x].
- SEL changes while IN_VALID = 1 and IN_READY = 0: permitted. IN_READY re-evaluates for the new SEL, and the word goes to the SEL value present on the accepting edge.
- Reset mid-operation: all buffered words are discarded immediately. Outputs return to reset values asynchronously.

Decomposition:
- Package demux12_pkg: WIDTH_DEF = 32, DEPTH_DEF = 2, localparam function for the pointer width, typedef word_t = logic [WIDTH_DEF-1:0].
- Sub-module fifo_sync:
  - Ports: CLK, RST, PUSH, POP, DIN, DOUT, FULL, EMPTY, LEVEL.
  - Instantiated twice. The top level contains only the steering logic: push0 = accept & ~SEL, push1 = accept & SEL.

Test Plan:
- Reset release, no traffic → OUT0_VALID = OUT1_VALID = 0, LEVEL0 = LEVEL1 = 0, IN_READY = 1.
- Push 32'hAAAAAAAA with SEL = 0, then 32'h55555555 with SEL = 1, both READY = 1 → one cycle later OUT0_DATA = AAAAAAAA and OUT1_DATA = 55555555, each popped once, and levels return to 0.
- OUT0_READY = 0, push 12345678 and 87654321 to channel 0 → LEVEL0 = 2, IN_READY = 0 for SEL = 0 but 1 for SEL = 1. Then push FFFFFFFF to channel 1 → it is accepted. Release OUT0_READY → channel 0 drains 12345678 then 87654321 in order.
- Channel 0 full, OUT0_READY = 1 and IN_VALID = 1 with SEL = 0 in the same cycle → push rejected, pop taken, LEVEL0 = 1, IN_READY rises on the next cycle.
- Continuous push/pop on channel 1 with an incrementing pattern 0..9 and DEPTH = 2 → outputs 0..9 in order, proving pointer wrap with no loss or duplication.
- Fill both channels, assert RST asynchronously mid-cycle → VALIDs and LEVELs go to 0 immediately, and the first post-reset push of 00000000 emerges alone.

Source files
------------

// File: rtl/demux12_pkg.sv
// rtl/demux12_pkg.sv - shared defaults and helpers for the 1-to-2 stream demux
// Purpose : default word/depth sizes, pointer-width helper and word type.
// Ports   : none (package).
package demux12_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;

  // Pointer width for a FIFO of the given depth; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/demux12_stream_if.sv
// rtl/demux12_stream_if.sv - producer/consumer handshake bundle for demux12_stream
// Purpose : groups the input stream, both output streams and the level taps.
// Ports   : master = producer + consumers (drives SEL/IN_*/OUTx_READY),
//           slave  = demux (drives IN_READY/OUTx_VALID/OUTx_DATA/LEVELx).
interface demux12_stream_if
  import demux12_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             SEL;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT0_VALID;
  logic             OUT0_READY;
  logic [WIDTH-1:0] OUT0_DATA;
  logic             OUT1_VALID;
  logic             OUT1_READY;
  logic [WIDTH-1:0] OUT1_DATA;
  logic [LW-1:0]    LEVEL0;
  logic [LW-1:0]    LEVEL1;

  modport master (
    output SEL, IN_VALID, IN_DATA, OUT0_READY, OUT1_READY,
    input  IN_READY, OUT0_VALID, OUT0_DATA, OUT1_VALID, OUT1_DATA, LEVEL0, LEVEL1
  );

  modport slave (
    input  SEL, IN_VALID, IN_DATA, OUT0_READY, OUT1_READY,
    output IN_READY, OUT0_VALID, OUT0_DATA, OUT1_VALID, OUT1_DATA, LEVEL0, LEVEL1
  );

endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with level counter, one per demux channel
// Purpose : stores words in order; full/empty come from the level counter.
// Ports   : CLK, RST (async, active-high), PUSH/DIN write the tail,
//           POP advances the head, DOUT = head entry, FULL, EMPTY, LEVEL.
module fifo_sync
  import demux12_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic                     POP,
  input  logic [WIDTH-1:0]         DIN,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL
);
  localparam int PW = ptr_width(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign FULL  = (level_q == LW'(DEPTH));
  assign EMPTY = (level_q == '0);
  assign LEVEL = level_q;
  // Head word comes straight from storage, so it is stable until popped.
  assign DOUT  = mem_q[rd_ptr_q];

  // Guarded locally too, so a stray push/pop can never over/underflow.
  assign do_push = PUSH & ~FULL;
  assign do_pop  = POP & ~EMPTY;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = DIN;
      wr_ptr_d        = wr_ptr_q + 1'b1;   // depth is a power of two: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/demux12_stream.sv
// rtl/demux12_stream.sv - 1-to-2 stream demultiplexer with a FIFO per output channel
// Purpose : steers each accepted input word to channel SEL; channels buffer
//           independently so one stalled consumer never blocks the other.
// Ports   : CLK, RST (async, active-high), bus (demux12_stream_if.slave):
//           SEL/IN_VALID/IN_READY/IN_DATA input stream, OUTx_VALID/READY/DATA
//           output streams, LEVELx channel occupancy.
module demux12_stream
  import demux12_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  demux12_stream_if.slave     bus
);
  logic full0, full1;
  logic empty0, empty1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Ready looks only at the selected channel; it never depends on a pop in
  // the same cycle, so there is no ready-to-ready combinational path.
  assign bus.IN_READY = bus.SEL ? ~full1 : ~full0;
  assign accept       = bus.IN_VALID & bus.IN_READY;
  assign push0        = accept & ~bus.SEL;
  assign push1        = accept &  bus.SEL;

  assign bus.OUT0_VALID = ~empty0;
  assign bus.OUT1_VALID = ~empty1;
  assign pop0           = bus.OUT0_VALID & bus.OUT0_READY;
  assign pop1           = bus.OUT1_VALID & bus.OUT1_READY;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (push0),
    .POP   (pop0),
    .DIN   (bus.IN_DATA),
    .DOUT  (bus.OUT0_DATA),
    .FULL  (full0),
    .EMPTY (empty0),
    .LEVEL (bus.LEVEL0)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (push1),
    .POP   (pop1),
    .DIN   (bus.IN_DATA),
    .DOUT  (bus.OUT1_DATA),
    .FULL  (full1),
    .EMPTY (empty1),
    .LEVEL (bus.LEVEL1)
  );

endmodule
